// File: rtl/mac_stats_pkg.sv
// Shared constants and types for the MAC statistics aggregator.
package mac_stats_pkg;

    // Width of the per-frame length field carried on stat_len.
    localparam int LEN_W = 16;

    // Number of counters kept for each channel.
    localparam int CNT_PER_CHAN = 3;

    // Counter select encodings on rd_sel.
    typedef enum logic [1:0] {
        SEL_GOOD_FRAMES = 2'd0,
        SEL_BAD_FRAMES  = 2'd1,
        SEL_GOOD_BYTES  = 2'd2,
        SEL_RESERVED    = 2'd3
    } rd_sel_e;

endpackage

// File: rtl/mac_stats_agg_stat_cnt.sv
// Single statistics counter: add, clear-on-read, global clear, saturate or wrap.
// The wrap output pulses combinationally whenever this cycle's add carries out.
module stat_cnt
    import mac_stats_pkg::*;
#(
    parameter int C_CNT_WIDTH = 48,
    parameter bit C_SATURATE  = 1'b1
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   clr_all,
    input  logic                   clr,
    input  logic                   add_en,
    input  logic [LEN_W-1:0]       add_val,
    output logic [C_CNT_WIDTH-1:0] cnt,
    output logic                   wrap
);

    logic [C_CNT_WIDTH-1:0] base;
    logic [C_CNT_WIDTH:0]   sum;
    logic [C_CNT_WIDTH-1:0] nxt;

    // Clear-on-read zeroes the base first so a same-cycle add is never lost.
    always_comb begin
        base = clr ? '0 : cnt;
        sum  = {1'b0, base} + {{(C_CNT_WIDTH + 1 - LEN_W){1'b0}}, add_val};
        wrap = add_en & sum[C_CNT_WIDTH];
        nxt  = base;
        if (add_en) begin
            if (sum[C_CNT_WIDTH] && C_SATURATE) begin
                nxt = '1;
            end else begin
                nxt = sum[C_CNT_WIDTH-1:0];
            end
        end
    end

    // Counter register; reset and global clear both win over any update.
    always_ff @(posedge clk) begin
        if (!aresetn || clr_all) begin
            cnt <= '0;
        end else begin
            cnt <= nxt;
        end
    end

endmodule

// File: rtl/mac_stats_agg.sv
// Per-channel MAC frame statistics with a one-cycle-latency read port.
module mac_stats_agg
    import mac_stats_pkg::*;
#(
    parameter int C_NUM_CHANNELS = 2,
    parameter int C_CNT_WIDTH    = 48,
    parameter bit C_SATURATE     = 1'b1
) (
    input  logic                            clk,
    input  logic                            aresetn,
    input  logic [C_NUM_CHANNELS-1:0]       stat_valid,
    input  logic [C_NUM_CHANNELS-1:0]       stat_good,
    input  logic [LEN_W*C_NUM_CHANNELS-1:0] stat_len,
    input  logic                            clr_all,
    input  logic                            rd_req,
    input  logic [2:0]                      rd_chan,
    input  logic [1:0]                      rd_sel,
    input  logic                            rd_clear,
    output logic                            rd_ack,
    output logic [C_CNT_WIDTH-1:0]          rd_data,
    output logic                            rd_err,
    output logic [C_NUM_CHANNELS-1:0]       ovf
);

    localparam logic [3:0] NUM_CH = 4'(C_NUM_CHANNELS);

    logic [C_CNT_WIDTH-1:0] good_frames [C_NUM_CHANNELS];
    logic [C_CNT_WIDTH-1:0] bad_frames  [C_NUM_CHANNELS];
    logic [C_CNT_WIDTH-1:0] good_bytes  [C_NUM_CHANNELS];
    logic [C_NUM_CHANNELS-1:0] wrap_gf, wrap_bf, wrap_gb;
    logic [C_NUM_CHANNELS-1:0] clr_hit;
    logic                      target_ok;
    logic                      rd_hit;
    logic [C_CNT_WIDTH-1:0]    rd_value;

    // Decode whether the request addresses a real counter and which channel it clears.
    always_comb begin
        target_ok = ({1'b0, rd_chan} < NUM_CH) && (rd_sel_e'(rd_sel) != SEL_RESERVED);
        rd_hit    = rd_req && target_ok;
        clr_hit   = '0;
        for (int n = 0; n < C_NUM_CHANNELS; n++) begin
            clr_hit[n] = rd_hit && rd_clear && (rd_chan == 3'(n));
        end
    end

    for (genvar n = 0; n < C_NUM_CHANNELS; n++) begin : g_chan
        stat_cnt #(.C_CNT_WIDTH(C_CNT_WIDTH), .C_SATURATE(C_SATURATE)) u_good_frames (
            .clk     (clk),
            .aresetn (aresetn),
            .clr_all (clr_all),
            .clr     (clr_hit[n] && (rd_sel_e'(rd_sel) == SEL_GOOD_FRAMES)),
            .add_en  (stat_valid[n] && stat_good[n]),
            .add_val (LEN_W'(1)),
            .cnt     (good_frames[n]),
            .wrap    (wrap_gf[n])
        );
        stat_cnt #(.C_CNT_WIDTH(C_CNT_WIDTH), .C_SATURATE(C_SATURATE)) u_bad_frames (
            .clk     (clk),
            .aresetn (aresetn),
            .clr_all (clr_all),
            .clr     (clr_hit[n] && (rd_sel_e'(rd_sel) == SEL_BAD_FRAMES)),
            .add_en  (stat_valid[n] && !stat_good[n]),
            .add_val (LEN_W'(1)),
            .cnt     (bad_frames[n]),
            .wrap    (wrap_bf[n])
        );
        stat_cnt #(.C_CNT_WIDTH(C_CNT_WIDTH), .C_SATURATE(C_SATURATE)) u_good_bytes (
            .clk     (clk),
            .aresetn (aresetn),
            .clr_all (clr_all),
            .clr     (clr_hit[n] && (rd_sel_e'(rd_sel) == SEL_GOOD_BYTES)),
            .add_en  (stat_valid[n] && stat_good[n]),
            .add_val (stat_len[LEN_W*n +: LEN_W]),
            .cnt     (good_bytes[n]),
            .wrap    (wrap_gb[n])
        );
    end

    // Select the addressed counter; out-of-range targets read as zero.
    always_comb begin
        rd_value = '0;
        for (int n = 0; n < C_NUM_CHANNELS; n++) begin
            if (rd_chan == 3'(n)) begin
                case (rd_sel_e'(rd_sel))
                    SEL_GOOD_FRAMES: rd_value = good_frames[n];
                    SEL_BAD_FRAMES:  rd_value = bad_frames[n];
                    SEL_GOOD_BYTES:  rd_value = good_bytes[n];
                    default:         rd_value = '0;
                endcase
            end
        end
    end

    // Sticky per-channel overflow: set by any counter carry, cleared by clear-on-read.
    always_ff @(posedge clk) begin
        if (!aresetn || clr_all) begin
            ovf <= '0;
        end else begin
            ovf <= (ovf & ~clr_hit) | wrap_gf | wrap_bf | wrap_gb;
        end
    end

    // Registered read response carrying the pre-update counter value.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            rd_ack  <= 1'b0;
            rd_err  <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_ack  <= rd_req;
            rd_err  <= rd_req && !target_ok;
            rd_data <= rd_hit ? rd_value : '0;
        end
    end

endmodule

// File: tb/tb_mac_stats_agg.sv
// Directed self-checking bench for mac_stats_agg: default 48-bit instance plus
// 16-bit saturating and wrapping instances driven by the same stimulus.
module tb_mac_stats_agg;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [1:0]  stat_valid;
    logic [1:0]  stat_good;
    logic [31:0] stat_len;
    logic        clr_all;
    logic        rd_req;
    logic [2:0]  rd_chan;
    logic [1:0]  rd_sel;
    logic        rd_clear;

    logic        rd_ack, rd_err;
    logic [47:0] rd_data;
    logic [1:0]  ovf;
    logic        s_rd_ack, s_rd_err;
    logic [15:0] s_rd_data;
    logic [1:0]  s_ovf;
    logic        w_rd_ack, w_rd_err;
    logic [15:0] w_rd_data;
    logic [1:0]  w_ovf;

    int checks = 0;
    int errors = 0;

    mac_stats_agg dut (
        .clk(clk), .aresetn(aresetn), .stat_valid(stat_valid), .stat_good(stat_good),
        .stat_len(stat_len), .clr_all(clr_all), .rd_req(rd_req), .rd_chan(rd_chan),
        .rd_sel(rd_sel), .rd_clear(rd_clear), .rd_ack(rd_ack), .rd_data(rd_data),
        .rd_err(rd_err), .ovf(ovf)
    );

    mac_stats_agg #(.C_NUM_CHANNELS(2), .C_CNT_WIDTH(16), .C_SATURATE(1'b1)) dut_sat (
        .clk(clk), .aresetn(aresetn), .stat_valid(stat_valid), .stat_good(stat_good),
        .stat_len(stat_len), .clr_all(clr_all), .rd_req(rd_req), .rd_chan(rd_chan),
        .rd_sel(rd_sel), .rd_clear(rd_clear), .rd_ack(s_rd_ack), .rd_data(s_rd_data),
        .rd_err(s_rd_err), .ovf(s_ovf)
    );

    mac_stats_agg #(.C_NUM_CHANNELS(2), .C_CNT_WIDTH(16), .C_SATURATE(1'b0)) dut_wrap (
        .clk(clk), .aresetn(aresetn), .stat_valid(stat_valid), .stat_good(stat_good),
        .stat_len(stat_len), .clr_all(clr_all), .rd_req(rd_req), .rd_chan(rd_chan),
        .rd_sel(rd_sel), .rd_clear(rd_clear), .rd_ack(w_rd_ack), .rd_data(w_rd_data),
        .rd_err(w_rd_err), .ovf(w_ovf)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, advance past the edge, then return inputs to idle.
    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] g, input logic [31:0] len,
                                 input logic ca, input logic rq, input logic [2:0] ch,
                                 input logic [1:0] sel, input logic rc);
        stat_valid = v;
        stat_good  = g;
        stat_len   = len;
        clr_all    = ca;
        rd_req     = rq;
        rd_chan    = ch;
        rd_sel     = sel;
        rd_clear   = rc;
        @(posedge clk);
        #1;
        stat_valid = '0;
        stat_good  = '0;
        stat_len   = '0;
        clr_all    = 1'b0;
        rd_req     = 1'b0;
        rd_chan    = '0;
        rd_sel     = '0;
        rd_clear   = 1'b0;
    endtask

    task automatic frame(input logic [1:0] v, input logic [1:0] g, input logic [31:0] len);
        applyStimulus(v, g, len, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
    endtask

    task automatic readReg(input logic [2:0] ch, input logic [1:0] sel, input logic rc);
        applyStimulus(2'b00, 2'b00, 32'd0, 1'b0, 1'b1, ch, sel, rc);
    endtask

    initial begin
        aresetn = 1'b0;
        applyStimulus(2'b00, 2'b00, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
        applyStimulus(2'b00, 2'b00, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
        checkOutput("reset_ack",  rd_ack,  0);
        checkOutput("reset_err",  rd_err,  0);
        checkOutput("reset_data", rd_data, 0);
        checkOutput("reset_ovf",  ovf,     0);
        aresetn = 1'b1;

        // Three good frames on channel 0.
        frame(2'b01, 2'b01, 32'd64);
        frame(2'b01, 2'b01, 32'd1518);
        frame(2'b01, 2'b01, 32'd9000);
        readReg(3'd0, 2'd0, 1'b0);
        checkOutput("gf0_ack",  rd_ack,  1);
        checkOutput("gf0_err",  rd_err,  0);
        checkOutput("gf0_data", rd_data, 3);
        readReg(3'd0, 2'd2, 1'b0);
        checkOutput("gb0_b2b_ack", rd_ack,  1);
        checkOutput("gb0_data",    rd_data, 10582);
        checkOutput("gb0_sat",     s_rd_data, 10582);
        frame(2'b00, 2'b00, 32'd0);
        checkOutput("idle_ack",  rd_ack,  0);
        checkOutput("idle_data", rd_data, 0);

        // Full-rate events on both channels: ch0 good 100 bytes, ch1 bad.
        for (int i = 0; i < 7; i++) frame(2'b11, 2'b01, 32'd100);
        readReg(3'd0, 2'd0, 1'b0);
        checkOutput("fullrate_gf0", rd_data, 10);
        readReg(3'd0, 2'd2, 1'b0);
        checkOutput("fullrate_gb0", rd_data, 11282);

        // Clear-on-read of ch1 bad_frames with a coincident bad frame.
        applyStimulus(2'b10, 2'b00, 32'd0, 1'b0, 1'b1, 3'd1, 2'd1, 1'b1);
        checkOutput("rdclr_bf1_data", rd_data, 7);
        readReg(3'd1, 2'd1, 1'b0);
        checkOutput("rdclr_bf1_after", rd_data, 1);
        checkOutput("rdclr_ovf1", ovf[1], 0);
        readReg(3'd1, 2'd0, 1'b0);
        checkOutput("gf1_zero", rd_data, 0);

        // Invalid targets return an error and change nothing.
        readReg(3'd5, 2'd0, 1'b0);
        checkOutput("badch_ack",  rd_ack,  1);
        checkOutput("badch_err",  rd_err,  1);
        checkOutput("badch_data", rd_data, 0);
        readReg(3'd0, 2'd3, 1'b1);
        checkOutput("sel3_err",  rd_err,  1);
        checkOutput("sel3_data", rd_data, 0);
        readReg(3'd2, 2'd2, 1'b1);
        checkOutput("ch2_err", rd_err, 1);
        readReg(3'd0, 2'd0, 1'b0);
        checkOutput("nochange_gf0", rd_data, 10);
        checkOutput("nochange_err", rd_err,  0);
        readReg(3'd0, 2'd2, 1'b0);
        checkOutput("nochange_gb0", rd_data, 11282);

        // Global clear with events on all channels and a same-cycle read.
        applyStimulus(2'b11, 2'b11, {16'd50, 16'd50}, 1'b1, 1'b1, 3'd0, 2'd0, 1'b0);
        checkOutput("clrall_read_pre", rd_data, 10);
        readReg(3'd0, 2'd0, 1'b0);
        checkOutput("clrall_gf0", rd_data, 0);
        readReg(3'd0, 2'd2, 1'b0);
        checkOutput("clrall_gb0",     rd_data,   0);
        checkOutput("clrall_gb0_sat", s_rd_data, 0);
        readReg(3'd1, 2'd1, 1'b0);
        checkOutput("clrall_bf1", rd_data, 0);
        readReg(3'd1, 2'd2, 1'b0);
        checkOutput("clrall_gb1", rd_data, 0);

        // Preload good_bytes to 65000, then push past 16-bit range.
        for (int i = 0; i < 7; i++) frame(2'b01, 2'b01, 32'd9000);
        frame(2'b01, 2'b01, 32'd2000);
        checkOutput("pre_ovf_sat",  s_ovf, 0);
        checkOutput("pre_ovf_wrap", w_ovf, 0);
        frame(2'b01, 2'b01, 32'd1000);
        readReg(3'd0, 2'd2, 1'b0);
        checkOutput("ovf_gb0_48",   rd_data,   66000);
        checkOutput("ovf_gb0_sat",  s_rd_data, 65535);
        checkOutput("ovf_gb0_wrap", w_rd_data, 464);
        checkOutput("ovf_48",   ovf,   0);
        checkOutput("ovf_sat",  s_ovf, 2'b01);
        checkOutput("ovf_wrap", w_ovf, 2'b01);
        readReg(3'd0, 2'd0, 1'b0);
        checkOutput("gf0_sat", s_rd_data, 9);
        readReg(3'd0, 2'd2, 1'b1);
        checkOutput("rdclr_gb0_sat", s_rd_data, 65535);
        checkOutput("rdclr_ovf_sat",  s_ovf, 0);
        checkOutput("rdclr_ovf_wrap", w_ovf, 0);
        readReg(3'd0, 2'd2, 1'b0);
        checkOutput("rdclr_gb0_after", s_rd_data, 0);

        // Reset asserted with a read request and events in the same cycle.
        aresetn = 1'b0;
        applyStimulus(2'b11, 2'b11, {16'd10, 16'd10}, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0);
        checkOutput("rst_read_ack",  rd_ack,  0);
        checkOutput("rst_read_err",  rd_err,  0);
        checkOutput("rst_read_data", rd_data, 0);
        checkOutput("rst_read_ovf",  ovf,     0);
        aresetn = 1'b1;
        frame(2'b00, 2'b00, 32'd0);
        checkOutput("post_rst_ack", rd_ack, 0);
        readReg(3'd0, 2'd0, 1'b0);
        checkOutput("post_rst_gf0", rd_data, 0);
        readReg(3'd1, 2'd0, 1'b0);
        checkOutput("post_rst_gf1", rd_data, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
